// File: rtl/pcsp_pkg.sv
// Shared encodings for the PC/SP/memory unit: operation codes, fault codes
// and the sequencer state enum.
package pcsp_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_FETCH  = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_PUSH   = 4'd4,
    OP_POP    = 4'd5,
    OP_CALL   = 4'd6,
    OP_RET    = 4'd7,
    OP_JUMP   = 4'd8,
    OP_BRANCH = 4'd9
  } op_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;
  localparam logic [1:0] FC_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2
  } state_t;

endpackage

// File: rtl/pcsp_mem_unit_spram.sv
// Single-port synchronous word RAM: write-enable plus registered read
// (read-before-write on the same address).
module spram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // write port and registered read port
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pcsp_mem_unit.sv
// Program counter, stack pointer, instruction register and word memory behind
// one valid/ready operation port, sequenced IDLE -> ACCESS [-> READ] -> IDLE.
module pcsp_mem_unit
  import pcsp_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned PC_RESET    = 0,
  parameter int unsigned SP_RESET    = (2**ADDR_W) - 1,
  parameter int unsigned STACK_FLOOR = (2**ADDR_W) - 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_offset,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] sp,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);
  localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);
  localparam logic [ADDR_W-1:0] FLOOR   = ADDR_W'(STACK_FLOOR);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t            state;
  logic [3:0]        cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_offset;
  logic [DATA_W-1:0] cur_wdata;

  logic [ADDR_W-1:0] sp_dec;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              wr_op;
  logic              is_read;
  logic              flt;
  logic [1:0]        flt_code;
  logic              unused_bits;

  assign sp_dec = sp - ONE;
  assign sp_inc = sp + ONE;
  // only the low ADDR_W bits of the offset matter: pc arithmetic wraps
  assign unused_bits = ^cur_offset;

  // decode the latched op: memory address/data, read path and fault check
  always_comb begin
    mem_addr  = pc;
    mem_wdata = cur_wdata;
    wr_op     = 1'b0;
    is_read   = 1'b0;
    flt_code  = FC_NONE;
    case (cur_op)
      OP_NOP: begin
        mem_addr = pc;
      end
      OP_FETCH: begin
        mem_addr = pc;
        is_read  = 1'b1;
      end
      OP_LOAD: begin
        mem_addr = cur_addr;
        is_read  = 1'b1;
      end
      OP_STORE: begin
        mem_addr = cur_addr;
        wr_op    = 1'b1;
      end
      OP_PUSH: begin
        mem_addr = sp_dec;
        wr_op    = 1'b1;
        flt_code = (sp == FLOOR) ? FC_OVF : FC_NONE;
      end
      OP_POP: begin
        mem_addr = sp;
        is_read  = 1'b1;
        flt_code = (sp == SP_INIT) ? FC_UNF : FC_NONE;
      end
      OP_CALL: begin
        mem_addr  = sp_dec;
        mem_wdata = DATA_W'(pc);
        wr_op     = 1'b1;
        flt_code  = (sp == FLOOR) ? FC_OVF : FC_NONE;
      end
      OP_RET: begin
        mem_addr = sp;
        is_read  = 1'b1;
        flt_code = (sp == SP_INIT) ? FC_UNF : FC_NONE;
      end
      OP_JUMP, OP_BRANCH: begin
        mem_addr = pc;
      end
      default: begin
        flt_code = FC_ILL;
      end
    endcase
    flt    = (flt_code != FC_NONE);
    mem_we = (state == ACCESS) && wr_op && !flt;
  end

  spram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // sequencer with registered architectural state and outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_ready   <= 1'b1;
      done       <= 1'b0;
      pc         <= PC_INIT;
      sp         <= SP_INIT;
      inst       <= '0;
      rdata      <= '0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      cur_op     <= 4'd0;
      cur_addr   <= '0;
      cur_offset <= '0;
      cur_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (op_valid) begin
            cur_op     <= op_code;
            cur_addr   <= op_addr;
            cur_offset <= op_offset;
            cur_wdata  <= op_wdata;
            op_ready   <= 1'b0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (flt) begin
            // first fault wins; the faulting op leaves every register alone
            if (!fault) begin
              fault_code <= flt_code;
            end
            fault    <= 1'b1;
            done     <= 1'b1;
            op_ready <= 1'b1;
            state    <= IDLE;
          end else if (is_read) begin
            state <= READ;
          end else begin
            case (cur_op)
              OP_PUSH:   sp <= sp_dec;
              OP_CALL: begin
                sp <= sp_dec;
                pc <= cur_addr;
              end
              OP_JUMP:   pc <= cur_addr;
              OP_BRANCH: pc <= pc + cur_offset[ADDR_W-1:0];
              default:   pc <= pc;
            endcase
            done     <= 1'b1;
            op_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        READ: begin
          case (cur_op)
            OP_FETCH: begin
              inst <= mem_rdata;
              pc   <= pc + ONE;
            end
            OP_LOAD:  rdata <= mem_rdata;
            OP_POP: begin
              rdata <= mem_rdata;
              sp    <= sp_inc;
            end
            OP_RET: begin
              pc <= mem_rdata[ADDR_W-1:0];
              sp <= sp_inc;
            end
            default:  rdata <= rdata;
          endcase
          done     <= 1'b1;
          op_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          op_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcsp_mem_unit.sv
// Self-checking bench for pcsp_mem_unit: a table of operations with expected
// results queued at issue and compared on done, plus hand-built corner sequences.
module tb_pcsp_mem_unit;
  import pcsp_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    op_code;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_offset;
  logic [DW-1:0] op_wdata;
  logic          done;
  logic [DW-1:0] rdata;
  logic [DW-1:0] inst;
  logic [AW-1:0] pc;
  logic [AW-1:0] sp;
  logic          fault;
  logic [1:0]    fault_code;

  int n_checks = 0;
  int n_errors = 0;
  int op_idx   = 0;

  // chk: 0 none, 1 compare rdata, 2 compare inst
  typedef struct {
    logic [3:0]    code;
    logic [AW-1:0] addr;
    logic [DW-1:0] off;
    logic [DW-1:0] wd;
    logic [AW-1:0] pc;
    logic [AW-1:0] sp;
    int            chk;
    logic [DW-1:0] data;
    logic          flt;
    logic [1:0]    fc;
    int            lat;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  pcsp_mem_unit dut (
    .clock      (clock),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_addr    (op_addr),
    .op_offset  (op_offset),
    .op_wdata   (op_wdata),
    .done       (done),
    .rdata      (rdata),
    .inst       (inst),
    .pc         (pc),
    .sp         (sp),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [3:0] code, input logic [AW-1:0] addr,
                              input logic [DW-1:0] off, input logic [DW-1:0] wd,
                              input logic [AW-1:0] epc, input logic [AW-1:0] esp,
                              input int chk, input logic [DW-1:0] data,
                              input logic flt, input logic [1:0] fc, input int lat);
    vec_t v;
    v.code = code; v.addr = addr; v.off = off; v.wd = wd;
    v.pc = epc; v.sp = esp; v.chk = chk; v.data = data;
    v.flt = flt; v.fc = fc; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL op%0d %s: got %h expected %h", op_idx, name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    vec_t e;
    int   n;
    bit   got;
    @(negedge clock);
    check("op_ready_before_issue", {31'd0, op_ready}, 32'd1);
    op_valid  = 1'b1;
    op_code   = v.code;
    op_addr   = v.addr;
    op_offset = v.off;
    op_wdata  = v.wd;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    op_valid  = 1'b0;
    op_code   = 4'($urandom_range(0, 15));
    op_addr   = AW'($urandom);
    op_offset = DW'($urandom);
    op_wdata  = DW'($urandom);
    n   = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      if (done) got = 1'b1;
      else begin
        @(posedge clock);
        #1;
        n++;
      end
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check("latency", n + 1, e.lat);
      check("pc", {22'd0, pc}, {22'd0, e.pc});
      check("sp", {22'd0, sp}, {22'd0, e.sp});
      check("fault", {31'd0, fault}, {31'd0, e.flt});
      check("fault_code", {30'd0, fault_code}, {30'd0, e.fc});
      check("op_ready_in_done", {31'd0, op_ready}, 32'd1);
      if (e.chk == 1) check("rdata", {16'd0, rdata}, {16'd0, e.data});
      else if (e.chk == 2) check("inst", {16'd0, inst}, {16'd0, e.data});
    end
    op_idx++;
  endtask

  task automatic check_reset_values();
    check("rst_pc", {22'd0, pc}, 32'd0);
    check("rst_sp", {22'd0, sp}, 32'd1023);
    check("rst_inst", {16'd0, inst}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_code", {30'd0, fault_code}, 32'd0);
    check("rst_op_ready", {31'd0, op_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 4'd0;
    op_addr = '0; op_offset = '0; op_wdata = '0;

    // pc, sp, data/inst expectations written out by hand from the op semantics
    tbl.push_back(mk(OP_STORE,  10'h005, 16'h0,    16'hBEEF, 10'h000, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_LOAD,   10'h005, 16'h0,    16'h0,    10'h000, 10'd1023, 1, 16'hBEEF, 1'b0, 2'b00, 3));
    tbl.push_back(mk(OP_STORE,  10'h000, 16'h0,    16'h1234, 10'h000, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_STORE,  10'h001, 16'h0,    16'h5678, 10'h000, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_STORE,  10'h3FF, 16'h0,    16'h0ABC, 10'h000, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_STORE,  10'h009, 16'h0,    16'h1111, 10'h000, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_FETCH,  10'h000, 16'h0,    16'h0,    10'h001, 10'd1023, 2, 16'h1234, 1'b0, 2'b00, 3));
    tbl.push_back(mk(OP_FETCH,  10'h000, 16'h0,    16'h0,    10'h002, 10'd1023, 2, 16'h5678, 1'b0, 2'b00, 3));
    tbl.push_back(mk(OP_JUMP,   10'h3FF, 16'h0,    16'h0,    10'h3FF, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_FETCH,  10'h000, 16'h0,    16'h0,    10'h000, 10'd1023, 2, 16'h0ABC, 1'b0, 2'b00, 3));
    tbl.push_back(mk(OP_JUMP,   10'h002, 16'h0,    16'h0,    10'h002, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_BRANCH, 10'h000, 16'hFFFD, 16'h0,    10'h3FF, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_JUMP,   10'h007, 16'h0,    16'h0,    10'h007, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_CALL,   10'h100, 16'h0,    16'h0,    10'h100, 10'd1022, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_LOAD,   10'h3FE, 16'h0,    16'h0,    10'h100, 10'd1022, 1, 16'h0007, 1'b0, 2'b00, 3));
    tbl.push_back(mk(OP_RET,    10'h000, 16'h0,    16'h0,    10'h007, 10'd1023, 0, 16'h0,    1'b0, 2'b00, 3));
    tbl.push_back(mk(OP_PUSH,   10'h000, 16'h0,    16'h00C3, 10'h007, 10'd1022, 0, 16'h0,    1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_POP,    10'h000, 16'h0,    16'h0,    10'h007, 10'd1023, 1, 16'h00C3, 1'b0, 2'b00, 3));
    tbl.push_back(mk(OP_NOP,    10'h000, 16'h0,    16'h0,    10'h007, 10'd1023, 1, 16'h00C3, 1'b0, 2'b00, 2));
    tbl.push_back(mk(OP_POP,    10'h000, 16'h0,    16'h0,    10'h007, 10'd1023, 1, 16'h00C3, 1'b1, 2'b10, 2));
    tbl.push_back(mk(4'hC,      10'h000, 16'h0,    16'h0,    10'h007, 10'd1023, 0, 16'h0,    1'b1, 2'b10, 2));
    tbl.push_back(mk(OP_RET,    10'h000, 16'h0,    16'h0,    10'h007, 10'd1023, 0, 16'h0,    1'b1, 2'b10, 2));
    tbl.push_back(mk(OP_STORE,  10'h2FF, 16'h0,    16'h5A5A, 10'h007, 10'd1023, 0, 16'h0,    1'b1, 2'b10, 2));

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_values();

    for (int i = 0; i < tbl.size(); i++) do_op(tbl[i]);

    // fill the stack down to the floor, then overflow it
    for (int i = 0; i < 255; i++)
      do_op(mk(OP_PUSH, 10'h000, 16'h0, DW'(i), 10'h007, AW'(1022 - i), 0, 16'h0, 1'b1, 2'b10, 2));
    check("sp_at_floor", {22'd0, sp}, 32'd768);
    do_op(mk(OP_PUSH, 10'h000, 16'h0, 16'hDEAD, 10'h007, 10'd768, 0, 16'h0,    1'b1, 2'b10, 2));
    do_op(mk(OP_CALL, 10'h123, 16'h0, 16'h0,    10'h007, 10'd768, 0, 16'h0,    1'b1, 2'b10, 2));
    do_op(mk(OP_LOAD, 10'h2FF, 16'h0, 16'h0,    10'h007, 10'd768, 1, 16'h5A5A, 1'b1, 2'b10, 3));
    do_op(mk(OP_POP,  10'h000, 16'h0, 16'h0,    10'h007, 10'd769, 1, 16'h00FE, 1'b1, 2'b10, 3));

    // reset during ACCESS of a STORE discards the write
    @(negedge clock);
    op_valid = 1'b1; op_code = OP_STORE; op_addr = 10'h009; op_wdata = 16'hAAAA;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    check_reset_values();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_reset_values();
    do_op(mk(OP_LOAD, 10'h009, 16'h0, 16'h0, 10'h000, 10'd1023, 1, 16'h1111, 1'b0, 2'b00, 3));

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pcsp_mem_unit.md
# pcsp_mem_unit

Parametrised successor to the processor's PC/SP/memory block. It merges program counter, stack pointer, instruction register and a single-port word memory behind one valid/ready operation port. A small sequencer runs fetch, load/store, push/pop and call/return, with stack-bounds checking. Sits between the control unit and the register file.

## Interface

Parameters:
- DATA_W, 16, memory word and data-port width; must be ≥ ADDR_W.
- ADDR_W, 10, address width; memory depth is 2^ADDR_W words.
- PC_RESET, 0, pc value after reset.
- SP_RESET, 2^ADDR_W−1, sp value after reset; this value means the stack is empty.
- STACK_FLOOR, 2^ADDR_W−256, lowest address the stack may occupy; must be < SP_RESET.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- op_valid  in  1  operation request.
- op_ready  out  1  unit can accept an operation this cycle.
- op_code  in  4  NOP, FETCH, LOAD, STORE, PUSH, POP, CALL, RET, JUMP, BRANCH.
- op_addr  in  ADDR_W  absolute address for LOAD, STORE, JUMP and CALL.
- op_offset  in  DATA_W  signed two's-complement offset for BRANCH.
- op_wdata  in  DATA_W  write data for STORE and PUSH.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  data returned by LOAD or POP.
- inst  out  DATA_W  instruction register.
- pc  out  ADDR_W  program counter.
- sp  out  ADDR_W  stack pointer; points at the top occupied word (full-descending stack).
- fault  out  1  sticky error flag.
- fault_code  out  2  01 overflow, 10 underflow, 11 illegal op; holds the first fault seen.

## Operation

State machine:
- IDLE: op_ready=1. On op_valid&&op_ready, latch all op_* fields and go to ACCESS.
- ACCESS: drive the memory. Read ops (FETCH, LOAD, POP, RET) go to READ. All other ops commit and return to IDLE.
- READ: capture the memory output, commit, return to IDLE.

Operations:
- FETCH: inst←mem[pc]; pc←pc+1.
- LOAD: rdata←mem[op_addr].
- STORE: mem[op_addr]←op_wdata.
- PUSH: sp←sp−1; mem[sp−1]←op_wdata.
- POP: rdata←mem[sp]; sp←sp+1.
- CALL: sp←sp−1; mem[sp−1]←zero-extended pc; pc←op_addr.
- RET: pc←mem[sp][ADDR_W−1:0]; sp←sp+1.
- JUMP: pc←op_addr.
- BRANCH: pc←pc+op_offset[ADDR_W−1:0].
- NOP: no state change; done still pulses.

Arithmetic: all pc arithmetic, including pc+1 and BRANCH, wraps modulo 2^ADDR_W.

Faults:
- Overflow: PUSH or CALL with sp==STACK_FLOOR.
- Underflow: POP or RET with sp==SP_RESET.
- Illegal op: any undefined op_code.
- A faulting op makes no memory write and changes no register; it takes the non-read path, and done still pulses.
- fault and fault_code are sticky until reset. Later ops still execute normally.

## Timing

- Memory is synchronous: address is presented in ACCESS, read data is valid in READ, and writes commit at the edge ending ACCESS.
- done is registered and is high in the IDLE cycle after commit. pc, sp, inst and rdata show the new values in that same cycle.
- Latency from the accept edge to done: 2 cycles for non-read ops, 3 cycles for read ops.
- op_ready is high while done is high, so back-to-back ops are allowed. Throughput is 1 op per 2 or 3 cycles.
- op_* inputs are ignored except at the accept edge.
- Reset values: state=IDLE, pc=PC_RESET, sp=SP_RESET, inst=0, rdata=0, done=0, fault=0, fault_code=00, op_ready=1.
- Reset asserted mid-operation aborts the op. A write whose commit edge has not occurred is discarded. Memory contents are not cleared.

## Structure

- Shared package pcsp_pkg holds the op_code encodings, fault_code encodings and the state enum (IDLE, ACCESS, READ).
- One sub-module, spram: single-port synchronous RAM with parameters DATA_W and ADDR_W, with write-enable and a registered read.
- Sequencer and pc/sp/inst/rdata registers live in the top module.

## Test plan

- Reset with defaults → pc=0, sp=1023, inst=0, op_ready=1. STORE addr 5 data 0xBEEF, then LOAD 5 → rdata=0xBEEF, done 2 and 3 cycles after their accept edges.
- Preload mem[0..1]=0x1234,0x5678, then FETCH twice back-to-back → inst=0x1234 then 0x5678, pc=2. op_ready is held throughout the done cycle.
- With pc=0x3FF, FETCH → pc=0x000. With pc=2, BRANCH offset 0xFFFD → pc=0x3FF.
- With pc=7, CALL 0x100 → sp=1022, mem[1022]=0x0007, pc=0x100. Then RET → pc=7, sp=1023.
- POP on an empty stack → fault=1, fault_code=10, sp unchanged, done pulses. Push down to sp=768, then PUSH → code stays 10, no write to mem[767].
- Issue STORE addr 9 data 0xAAAA and assert reset during ACCESS → mem[9] unchanged, all outputs at reset values.
